// File: rtl/multi_sprite_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_sprite_renderer_if
// Description : Video timing, sprite position handshake and rendered-pixel
//               signals shared between a video source and the renderer.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_sprite_renderer_if #(
  parameter int N_SPRITES = 2
);
  logic [10:0]             hcount;
  logic [9:0]              vcount;
  logic                    display;
  logic                    frame_start;
  logic [23:0]             background;
  logic [24*N_SPRITES-1:0] colors;
  logic [11*N_SPRITES-1:0] pos_x;
  logic [10*N_SPRITES-1:0] pos_y;
  logic                    pos_valid;
  logic                    pos_ready;
  logic [23:0]             pixel;
  logic                    occupied;
  logic [2:0]              sprite_id;
  logic                    collision;
  logic [19:0]             overlap_count;

  // Video source / position producer side
  modport master (
    output hcount, vcount, display, frame_start, background,
    output colors, pos_x, pos_y, pos_valid,
    input  pos_ready, pixel, occupied, sprite_id, collision, overlap_count
  );

  // Renderer side
  modport slave (
    input  hcount, vcount, display, frame_start, background,
    input  colors, pos_x, pos_y, pos_valid,
    output pos_ready, pixel, occupied, sprite_id, collision, overlap_count
  );
endinterface
`default_nettype wire

// File: rtl/multi_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module      : multi_sprite_renderer
// Description : Renders up to N_SPRITES circular sprites (solid disc plus a
//               half-blended halo ring) over a background in a 3-stage
//               pipeline; double-buffers positions and reports inner-disc
//               overlaps per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_sprite_renderer #(
  parameter int N_SPRITES = 2,
  parameter int RADIUS    = 16,
  parameter int HALO      = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  multi_sprite_renderer_if.slave   bus
);

  localparam int          C_R_OUT    = RADIUS + HALO;
  localparam logic [24:0] C_R_IN_SQ  = 25'(RADIUS * RADIUS);
  localparam logic [24:0] C_R_OUT_SQ = 25'(C_R_OUT * C_R_OUT);
  localparam logic [11:0] C_OFF_X    = 12'(C_R_OUT);
  localparam logic [10:0] C_OFF_Y    = 11'(C_R_OUT);

  // Position double buffer
  logic [10:0]          shadow_x_q [N_SPRITES];
  logic [9:0]           shadow_y_q [N_SPRITES];
  logic                 pending_q;
  logic [11:0]          cx_q       [N_SPRITES];
  logic [10:0]          cy_q       [N_SPRITES];
  logic [N_SPRITES-1:0] enabled_q;

  // Pipeline
  logic [11:0] dx_q [N_SPRITES];
  logic [11:0] dy_q [N_SPRITES];
  logic [24:0] d2_q [N_SPRITES];
  logic        s1_disp_q, s2_disp_q;
  logic [23:0] s1_bg_q, s2_bg_q;

  // Outputs and frame statistics
  logic [23:0] pixel_q;
  logic        occupied_q;
  logic [2:0]  sprite_id_q;
  logic        collision_q;
  logic [19:0] overlap_count_q;
  logic [19:0] frame_cnt_q;
  logic        frame_flag_q;

  logic                 w_xfer;
  logic [N_SPRITES-1:0] w_inner;
  logic [N_SPRITES-1:0] w_halo;
  logic                 w_hit;
  logic                 w_win_inner;
  logic [2:0]           w_win;
  logic [23:0]          w_col;
  logic [23:0]          w_blend;
  logic [3:0]           w_ninner;
  logic                 w_overlap;

  // Ready is forced high while reset is held so the producer never stalls on it
  assign w_xfer        = bus.pos_valid & ~pending_q;
  assign bus.pos_ready = ~pending_q | ~reset_n;

  // Shadow capture on handshake; promotion to the active set on frame_start.
  // A transfer can only happen with pending clear, so the two never collide.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      enabled_q <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow_x_q[i] <= '0;
        shadow_y_q[i] <= '0;
        cx_q[i]       <= '0;
        cy_q[i]       <= '0;
      end
    end else if (w_xfer) begin
      pending_q <= 1'b1;
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow_x_q[i] <= bus.pos_x[11*i +: 11];
        shadow_y_q[i] <= bus.pos_y[10*i +: 10];
      end
    end else if (bus.frame_start && pending_q) begin
      pending_q <= 1'b0;
      enabled_q <= '1;
      for (int i = 0; i < N_SPRITES; i++) begin
        cx_q[i] <= {1'b0, shadow_x_q[i]} + C_OFF_X;
        cy_q[i] <= {1'b0, shadow_y_q[i]} + C_OFF_Y;
      end
    end
  end

  // Delay display/background alongside the distance computation
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_disp_q <= 1'b0;
      s2_disp_q <= 1'b0;
      s1_bg_q   <= '0;
      s2_bg_q   <= '0;
    end else begin
      s1_disp_q <= bus.display;
      s2_disp_q <= s1_disp_q;
      s1_bg_q   <= bus.background;
      s2_bg_q   <= s1_bg_q;
    end
  end

  generate
    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_sprite
      logic [11:0] w_h;
      logic [11:0] w_v;
      logic [11:0] w_cy;
      assign w_h  = {1'b0, bus.hcount};
      assign w_v  = {2'b0, bus.vcount};
      assign w_cy = {1'b0, cy_q[gi]};

      // Stages 1 and 2: absolute offsets, then squared distance (fits 25 bits)
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          dx_q[gi] <= '0;
          dy_q[gi] <= '0;
          d2_q[gi] <= '0;
        end else begin
          dx_q[gi] <= (w_h >= cx_q[gi]) ? (w_h - cx_q[gi]) : (cx_q[gi] - w_h);
          dy_q[gi] <= (w_v >= w_cy)     ? (w_v - w_cy)     : (w_cy - w_v);
          d2_q[gi] <= ({13'd0, dx_q[gi]} * {13'd0, dx_q[gi]})
                    + ({13'd0, dy_q[gi]} * {13'd0, dy_q[gi]});
        end
      end

      assign w_inner[gi] = enabled_q[gi] & s2_disp_q & (d2_q[gi] <= C_R_IN_SQ);
      assign w_halo[gi]  = enabled_q[gi] & s2_disp_q & ~w_inner[gi]
                         & (d2_q[gi] <= C_R_OUT_SQ);
    end
  endgenerate

  // Lowest-index hit wins; also count inner hits for overlap detection
  always_comb begin
    w_hit       = 1'b0;
    w_win       = 3'd0;
    w_win_inner = 1'b0;
    w_col       = 24'd0;
    w_ninner    = 4'd0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      w_ninner = w_ninner + {3'd0, w_inner[i]};
      if (w_inner[i] || w_halo[i]) begin
        w_hit       = 1'b1;
        w_win       = 3'(i);
        w_win_inner = w_inner[i];
        w_col       = bus.colors[24*i +: 24];
      end
    end
    for (int c = 0; c < 3; c++) begin
      w_blend[8*c +: 8] = 8'(({1'b0, w_col[8*c +: 8]} + {1'b0, s2_bg_q[8*c +: 8]}) >> 1);
    end
    w_overlap = (w_ninner >= 4'd2);
  end

  // Stage 3: registered pixel outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pixel_q     <= '0;
      occupied_q  <= 1'b0;
      sprite_id_q <= '0;
    end else begin
      pixel_q     <= w_hit ? (w_win_inner ? w_col : w_blend) : 24'd0;
      occupied_q  <= w_hit;
      sprite_id_q <= w_hit ? w_win : 3'd0;
    end
  end

  // Per-frame overlap statistics; an overlap on the frame_start cycle opens the new frame
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_cnt_q     <= '0;
      frame_flag_q    <= 1'b0;
      collision_q     <= 1'b0;
      overlap_count_q <= '0;
    end else if (bus.frame_start) begin
      collision_q     <= frame_flag_q;
      overlap_count_q <= frame_cnt_q;
      frame_cnt_q     <= w_overlap ? 20'd1 : 20'd0;
      frame_flag_q    <= w_overlap;
    end else if (w_overlap) begin
      frame_flag_q <= 1'b1;
      if (frame_cnt_q != 20'hFFFFF) begin
        frame_cnt_q <= frame_cnt_q + 20'd1;
      end
    end
  end

  assign bus.pixel         = pixel_q;
  assign bus.occupied      = occupied_q;
  assign bus.sprite_id     = sprite_id_q;
  assign bus.collision     = collision_q;
  assign bus.overlap_count = overlap_count_q;

endmodule
`default_nettype wire

// File: doc/multi_sprite_renderer.md
MULTI_SPRITE_RENDERER -- requirements
Module: multi_sprite_renderer

Interface
REQ-001 Parameter N_SPRITES, default 2: number of circular sprite channels, range 1..8.
REQ-002 Parameter RADIUS, default 16: inner solid radius in pixels.
REQ-003 Parameter HALO, default 8: halo ring width; outer radius R_OUT = RADIUS + HALO.
REQ-004 Port clock, input, 1: single clock; all logic rising-edge.
REQ-005 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 Port hcount, input, 11: current pixel column.
REQ-007 Port vcount, input, 10: current pixel row.
REQ-008 Port display, input, 1: pixel is in the visible area.
REQ-009 Port frame_start, input, 1: one-cycle pulse at start of vertical blank.
REQ-010 Port background, input, 24: background RGB for the current pixel.
REQ-011 Port colors, input, 24*N_SPRITES: per-sprite RGB; sprite i occupies bits [24i+23:24i].
REQ-012 Port pos_x, input, 11*N_SPRITES: per-sprite bounding-box left edge.
REQ-013 Port pos_y, input, 10*N_SPRITES: per-sprite bounding-box top edge.
REQ-014 Port pos_valid, input, 1: new position set offered.
REQ-015 Port pos_ready, output, 1: shadow register free to accept a position set.
REQ-016 Port pixel, output, 24: rendered RGB; 0 when no sprite hit.
REQ-017 Port occupied, output, 1: some sprite covers this pixel.
REQ-018 Port sprite_id, output, 3: index of the winning sprite; 0 when not occupied.
REQ-019 Port collision, output, 1: previous frame had at least one inner-inner overlap pixel.
REQ-020 Port overlap_count, output, 20: count of overlap pixels in the previous frame.

Function
REQ-021 Position transfer SHALL complete when pos_valid and pos_ready are both high on a clock edge; all N positions are then captured into the shadow set and pending is set.
REQ-022 pos_ready SHALL equal NOT pending.
REQ-023 On frame_start with pending=1, shadow SHALL copy to the active set; every sprite is marked enabled and pending clears.
REQ-024 If frame_start and a transfer occur in the same cycle, the transfer SHALL land in the shadow set as pending and become active only at the next frame_start.
REQ-025 Sprite i center SHALL be (pos_x_i + R_OUT, pos_y_i + R_OUT), computed at 12/11 bits without truncation.
REQ-026 Stage 1: dx = |hcount - cx|, dy = |vcount - cy|, each 12 bits; hcount, vcount, display and background are delayed alongside.
REQ-027 Stage 2: d2 = dx*dx + dy*dy, 25 bits with no overflow.
REQ-028 Stage 3: inner_i = enabled_i & display & (d2 <= RADIUS^2); halo_i = enabled_i & display & !inner_i & (d2 <= R_OUT^2).
REQ-029 Winner SHALL be the lowest index i with inner_i or halo_i.
REQ-030 pixel SHALL be color_w when the winner hit is inner; for a halo hit, each channel is (color_w_ch + background_ch) >> 1, summed in 9 bits.
REQ-031 Output latency SHALL be exactly 3 clocks: pixel, occupied and sprite_id reflect the hcount/vcount/display/background presented 3 cycles earlier.
REQ-032 An overlap pixel is a stage-3 pixel where two or more inner_i are high.
REQ-033 Each overlap pixel SHALL increment the internal frame counter, saturating at 20'hFFFFF, and set the internal collision flag.
REQ-034 On frame_start, collision and overlap_count SHALL load the internal values and the internal values clear.
REQ-035 If an overlap pixel coincides with frame_start, it SHALL count toward the new frame.
REQ-036 Sprites SHALL stay disabled (never hit) until their first activation.

Reset
REQ-037 With reset_n low at a clock edge, the block SHALL clear: pixel, occupied, sprite_id, collision, overlap_count, all pipeline valids, enables, pending, and the internal counter and flag.
REQ-038 pos_ready SHALL be 1 during and immediately after reset.
REQ-039 Reset mid-frame or mid-pending SHALL discard shadow and active positions.

Verification
REQ-040 Reset, then sweep one frame with no transfer -> occupied=0 and pixel=0 everywhere; collision=0.
REQ-041 Transfer sprite0 at (100,100), then frame_start. Pixel (124,124) -> 3 cycles later pixel=color0, sprite_id=0. Pixel (124,144) with d2=400 (halo) -> averaged color. Pixel (124,149) -> occupied=0.
REQ-042 Transfer two sprites both at (200,50), then run a full frame and pulse frame_start -> sprite_id=0 on the overlap; collision=1; overlap_count = number of inner pixels (d2<=256) of one disc.
REQ-043 After a transfer with pending=1, drive pos_valid high with different data -> pos_ready=0 and the data is ignored; frame_start applies the first set only.
REQ-044 Pulse frame_start in the same cycle as a transfer -> the old positions remain rendered this frame; the new positions take effect after the next frame_start.
REQ-045 Assert reset_n=0 for one cycle mid-frame with sprites active -> all outputs are 0 next cycle, and no sprite is drawn until a new transfer and frame_start.
